writeback: RTL and testbench

- Retire stage directly downstream of the execute stage.
- Accepts one completed instruction result per valid/ready handshake. Commits it to the register file (low half, plus optional EDX high half for MUL/DIV) or to memory (req/ack), then merges the arithmetic flags into the architectural EFLAGS register.
- Emits a retire pulse and a running retire count for the trace/proof harness.

---
 rtl/writeback.sv | 203 ++++++++++++++++++++
 tb/tb_writeback.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback.sv
// rtl/writeback.sv - retire stage: register/memory commit, EFLAGS merge, retire trace
module writeback #(
    parameter logic [31:0] EFLAGS_RESET = 32'h0000_0002,
    parameter logic [2:0]  EDX_IDX      = 3'd2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_result_hi,
    input  logic        ex_wr_hi,
    input  logic        ex_no_wr,
    input  logic [1:0]  ex_dst_kind,
    input  logic [2:0]  ex_dst_reg,
    input  logic [1:0]  ex_dst_size,
    input  logic [31:0] ex_dst_addr,
    input  logic [31:0] ex_flags,
    input  logic [31:0] ex_flags_mask,
    output logic        rf_we,
    output logic [2:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [1:0]  rf_wsize,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_size,
    output logic [31:0] eflags_q,
    output logic        retire,
    output logic [31:0] retire_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_LO,
        S_WR_HI,
        S_MEM,
        S_RETIRE
    } state_t;

    state_t      state_q, state_d;

    // Held copies of the accepted op that are still needed after the accept edge.
    logic [31:0] h_result_hi_q, h_result_hi_d;
    logic        h_wr_hi_q, h_wr_hi_d;
    logic [31:0] h_flags_q, h_flags_d;
    logic [31:0] h_mask_q, h_mask_d;

    // Registered outputs; data fields hold their last value, only strobes are qualified.
    logic        rf_we_q, rf_we_d;
    logic [2:0]  rf_waddr_q, rf_waddr_d;
    logic [31:0] rf_wdata_q, rf_wdata_d;
    logic [1:0]  rf_wsize_q, rf_wsize_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]  mem_size_q, mem_size_d;
    logic        retire_q, retire_d;
    logic [31:0] retire_count_q, retire_count_d;
    logic [31:0] eflags_d;
    logic [31:0] eflags_merged;

    logic        accept;

    assign ex_ready     = (state_q == S_IDLE);
    assign accept       = ex_valid && (state_q == S_IDLE);
    assign rf_we        = rf_we_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign rf_wsize     = rf_wsize_q;
    assign mem_req      = mem_req_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_size     = mem_size_q;
    assign retire       = retire_q;
    assign retire_count = retire_count_q;

    // Masked flag merge with the architecturally fixed bits applied last.
    always_comb begin
        eflags_merged     = (eflags_q & ~h_mask_q) | (h_flags_q & h_mask_q);
        eflags_merged[1]  = 1'b1;
        eflags_merged[3]  = 1'b0;
        eflags_merged[5]  = 1'b0;
        eflags_merged[15] = 1'b0;
    end

    // Next-state and next-output logic; outputs are registered one edge ahead of their state.
    always_comb begin
        state_d        = state_q;
        h_result_hi_d  = h_result_hi_q;
        h_wr_hi_d      = h_wr_hi_q;
        h_flags_d      = h_flags_q;
        h_mask_d       = h_mask_q;
        rf_we_d        = 1'b0;
        rf_waddr_d     = rf_waddr_q;
        rf_wdata_d     = rf_wdata_q;
        rf_wsize_d     = rf_wsize_q;
        mem_req_d      = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        mem_size_d     = mem_size_q;
        eflags_d       = eflags_q;
        retire_count_d = retire_count_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    h_result_hi_d = ex_result_hi;
                    h_wr_hi_d     = ex_wr_hi;
                    h_flags_d     = ex_flags;
                    h_mask_d      = ex_flags_mask;
                    if (ex_no_wr || ex_dst_kind == 2'd0 || ex_dst_kind == 2'd3) begin
                        state_d = S_RETIRE;
                    end else if (ex_dst_kind == 2'd1) begin
                        state_d    = S_WR_LO;
                        rf_we_d    = 1'b1;
                        rf_waddr_d = ex_dst_reg;
                        rf_wdata_d = ex_result;
                        rf_wsize_d = ex_dst_size;
                    end else begin
                        state_d     = S_MEM;
                        mem_req_d   = 1'b1;
                        mem_addr_d  = ex_dst_addr;
                        mem_wdata_d = ex_result;
                        mem_size_d  = ex_dst_size;
                    end
                end
            end
            S_WR_LO: begin
                if (h_wr_hi_q) begin
                    state_d    = S_WR_HI;
                    rf_we_d    = 1'b1;
                    rf_waddr_d = EDX_IDX;
                    rf_wdata_d = h_result_hi_q;
                    rf_wsize_d = 2'd2;
                end else begin
                    state_d = S_RETIRE;
                end
            end
            S_WR_HI: begin
                state_d = S_RETIRE;
            end
            S_MEM: begin
                if (mem_ack) begin
                    state_d = S_RETIRE;
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            S_RETIRE: begin
                state_d        = S_IDLE;
                eflags_d       = eflags_merged;
                retire_count_d = retire_count_q + 32'd1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        retire_d = (state_d == S_RETIRE);
    end

    // State, hold and output registers; reset drops any in-flight op immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            h_result_hi_q  <= 32'd0;
            h_wr_hi_q      <= 1'b0;
            h_flags_q      <= 32'd0;
            h_mask_q       <= 32'd0;
            rf_we_q        <= 1'b0;
            rf_waddr_q     <= 3'd0;
            rf_wdata_q     <= 32'd0;
            rf_wsize_q     <= 2'd0;
            mem_req_q      <= 1'b0;
            mem_addr_q     <= 32'd0;
            mem_wdata_q    <= 32'd0;
            mem_size_q     <= 2'd0;
            retire_q       <= 1'b0;
            retire_count_q <= 32'd0;
            eflags_q       <= EFLAGS_RESET;
        end else begin
            state_q        <= state_d;
            h_result_hi_q  <= h_result_hi_d;
            h_wr_hi_q      <= h_wr_hi_d;
            h_flags_q      <= h_flags_d;
            h_mask_q       <= h_mask_d;
            rf_we_q        <= rf_we_d;
            rf_waddr_q     <= rf_waddr_d;
            rf_wdata_q     <= rf_wdata_d;
            rf_wsize_q     <= rf_wsize_d;
            mem_req_q      <= mem_req_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_size_q     <= mem_size_d;
            retire_q       <= retire_d;
            retire_count_q <= retire_count_d;
            eflags_q       <= eflags_d;
        end
    end

endmodule

// File: tb/tb_writeback.sv
// tb/tb_writeback.sv - self-checking bench for the writeback retire stage
module tb_writeback;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_result;
    logic [31:0] ex_result_hi;
    logic        ex_wr_hi;
    logic        ex_no_wr;
    logic [1:0]  ex_dst_kind;
    logic [2:0]  ex_dst_reg;
    logic [1:0]  ex_dst_size;
    logic [31:0] ex_dst_addr;
    logic [31:0] ex_flags;
    logic [31:0] ex_flags_mask;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [1:0]  rf_wsize;
    logic        mem_req;
    logic        mem_ack;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_size;
    logic [31:0] eflags_q;
    logic        retire;
    logic [31:0] retire_count;

    int total;
    int bad;

    logic [36:0] rf_q[$];
    logic [31:0] model_flags;
    logic [31:0] model_count;

    writeback dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_result     (ex_result),
        .ex_result_hi  (ex_result_hi),
        .ex_wr_hi      (ex_wr_hi),
        .ex_no_wr      (ex_no_wr),
        .ex_dst_kind   (ex_dst_kind),
        .ex_dst_reg    (ex_dst_reg),
        .ex_dst_size   (ex_dst_size),
        .ex_dst_addr   (ex_dst_addr),
        .ex_flags      (ex_flags),
        .ex_flags_mask (ex_flags_mask),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .rf_wsize      (rf_wsize),
        .mem_req       (mem_req),
        .mem_ack       (mem_ack),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_size      (mem_size),
        .eflags_q      (eflags_q),
        .retire        (retire),
        .retire_count  (retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] merge_flags(input logic [31:0] cur, input logic [31:0] f, input logic [31:0] m);
        logic [31:0] r;
        r = (cur & ~m) | (f & m);
        r[1] = 1'b1;
        r[3] = 1'b0;
        r[5] = 1'b0;
        r[15] = 1'b0;
        return r;
    endfunction

    // Register-write scoreboard: every rf_we cycle must match the next expected write in order.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rf_we) begin
                logic [36:0] exp;
                total++;
                if (rf_q.size() == 0) begin
                    bad++;
                    $display("FAIL rf_unexpected: got addr=%0d data=%h size=%0d, required no write", rf_waddr, rf_wdata, rf_wsize);
                end else begin
                    exp = rf_q.pop_front();
                    if ({rf_waddr, rf_wdata, rf_wsize} !== exp) begin
                        bad++;
                        $display("FAIL rf_write: got %h_%h_%h, required %h_%h_%h", rf_waddr, rf_wdata, rf_wsize, exp[36:34], exp[33:2], exp[1:0]);
                    end
                end
            end
            if (rf_we && mem_req) begin
                total++;
                bad++;
                $display("FAIL rf_mem_overlap: rf_we=%b mem_req=%b, required not both", rf_we, mem_req);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_op(input logic [1:0] kind, input logic no_wr, input logic wr_hi,
                             input logic [2:0] dreg, input logic [1:0] dsize, input logic [31:0] addr,
                             input logic [31:0] res, input logic [31:0] hi,
                             input logic [31:0] flg, input logic [31:0] msk);
        int n;
        n = 0;
        @(negedge clk);
        while (!ex_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ex_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: ex_ready=%b, required 1", ex_ready);
        end
        ex_dst_kind   = kind;
        ex_no_wr      = no_wr;
        ex_wr_hi      = wr_hi;
        ex_dst_reg    = dreg;
        ex_dst_size   = dsize;
        ex_dst_addr   = addr;
        ex_result     = res;
        ex_result_hi  = hi;
        ex_flags      = flg;
        ex_flags_mask = msk;
        ex_valid      = 1'b1;
        @(posedge clk);
        #1;
        ex_valid      = 1'b0;
        ex_result     = $urandom;
        ex_result_hi  = $urandom;
        ex_dst_addr   = $urandom;
        ex_dst_reg    = 3'($urandom);
        ex_flags      = $urandom;
        ex_flags_mask = $urandom;
        if (!no_wr && kind == 2'd1) begin
            rf_q.push_back({dreg, res, dsize});
            if (wr_hi) rf_q.push_back({3'd2, hi, 2'd2});
        end
        model_flags = merge_flags(model_flags, flg, msk);
        model_count = model_count + 32'd1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++;
        if ({rf_we, mem_req, retire} !== 3'b000) begin
            bad++;
            $display("FAIL reset_strobes: got %b, required 000", {rf_we, mem_req, retire});
        end
        total++;
        if ({rf_waddr, rf_wdata, rf_wsize, mem_addr, mem_wdata, mem_size} !== 103'd0) begin
            bad++;
            $display("FAIL reset_data: got nonzero output data, required 0");
        end
        total++;
        if (eflags_q !== 32'h2 || retire_count !== 32'd0) begin
            bad++;
            $display("FAIL reset_flags_count: got %h/%0d, required 00000002/0", eflags_q, retire_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_flags = 32'h2;
        model_count = 32'd0;
        #1;
        total++;
        if (ex_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: got %b, required 1", ex_ready);
        end
    endtask

    task automatic test_add();
        accept_op(2'd1, 1'b0, 1'b0, 3'd3, 2'd2, 32'h0, 32'h1234_5678, 32'h0, 32'h41, 32'h8D5);
        total++;
        if (rf_we !== 1'b1 || retire !== 1'b0) begin
            bad++;
            $display("FAIL add_n1: rf_we=%b retire=%b, required 1/0", rf_we, retire);
        end
        step();
        total++;
        if (retire !== 1'b1 || rf_we !== 1'b0 || rf_wdata !== 32'h1234_5678) begin
            bad++;
            $display("FAIL add_n2: retire=%b rf_we=%b wdata=%h, required 1/0/12345678", retire, rf_we, rf_wdata);
        end
        step();
        total++;
        if (ex_ready !== 1'b1 || retire !== 1'b0 || eflags_q !== 32'h43 || retire_count !== 32'd1) begin
            bad++;
            $display("FAIL add_n3: ready=%b retire=%b eflags=%h count=%0d, required 1/0/00000043/1", ex_ready, retire, eflags_q, retire_count);
        end
    endtask

    task automatic test_mul(input logic [2:0] dreg);
        accept_op(2'd1, 1'b0, 1'b1, dreg, 2'd2, 32'h0, 32'hFFFF_0001, 32'h0000_FFFE, 32'h0, 32'h0);
        total++;
        if (rf_we !== 1'b1) begin
            bad++;
            $display("FAIL mul_n1: rf_we=%b, required 1", rf_we);
        end
        step();
        total++;
        if (rf_we !== 1'b1 || retire !== 1'b0) begin
            bad++;
            $display("FAIL mul_n2: rf_we=%b retire=%b, required 1/0", rf_we, retire);
        end
        step();
        total++;
        if (retire !== 1'b1 || rf_we !== 1'b0 || rf_waddr !== 3'd2 || rf_wdata !== 32'h0000_FFFE) begin
            bad++;
            $display("FAIL mul_n3: retire=%b rf_we=%b waddr=%0d wdata=%h, required 1/0/2/0000fffe", retire, rf_we, rf_waddr, rf_wdata);
        end
        step();
        total++;
        if (eflags_q !== model_flags || retire_count !== model_count) begin
            bad++;
            $display("FAIL mul_after: eflags=%h count=%0d, required %h/%0d", eflags_q, retire_count, model_flags, model_count);
        end
    endtask

    task automatic test_cmp();
        accept_op(2'd1, 1'b1, 1'b0, 3'd5, 2'd2, 32'h0, 32'hAAAA_5555, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        total++;
        if (retire !== 1'b1 || rf_we !== 1'b0) begin
            bad++;
            $display("FAIL cmp_n1: retire=%b rf_we=%b, required 1/0", retire, rf_we);
        end
        step();
        total++;
        if (eflags_q !== 32'hFFFF_7FD7 || retire !== 1'b0 || ex_ready !== 1'b1) begin
            bad++;
            $display("FAIL cmp_flags: eflags=%h retire=%b ready=%b, required ffff7fd7/0/1", eflags_q, retire, ex_ready);
        end
    endtask

    task automatic test_mem();
        int req_cycles;
        int bad_cycles;
        int retires;
        mem_ack = 1'b1;
        step();
        step();
        mem_ack = 1'b0;
        total++;
        if (retire !== 1'b0 || mem_req !== 1'b0) begin
            bad++;
            $display("FAIL mem_idle_ack: retire=%b mem_req=%b, required 0/0", retire, mem_req);
        end
        accept_op(2'd2, 1'b0, 1'b1, 3'd1, 2'd1, 32'h0000_1000, 32'hDEAD_BEEF, 32'h1111_2222, 32'h0, 32'h0);
        req_cycles = 0;
        bad_cycles = 0;
        retires = 0;
        for (int i = 1; i <= 5; i++) begin
            if (mem_req === 1'b1) req_cycles++;
            if (mem_addr !== 32'h0000_1000 || mem_wdata !== 32'hDEAD_BEEF || mem_size !== 2'd1 ||
                ex_ready !== 1'b0 || retire !== 1'b0) bad_cycles++;
            if (i == 5) mem_ack = 1'b1;
            if (i < 5) step();
        end
        step();
        mem_ack = 1'b0;
        total++;
        if (req_cycles != 5 || bad_cycles != 0) begin
            bad++;
            $display("FAIL mem_hold: req_cycles=%0d unstable=%0d, required 5/0", req_cycles, bad_cycles);
        end
        for (int i = 0; i < 4; i++) begin
            if (retire === 1'b1) retires++;
            if (i == 0 && mem_req !== 1'b0) bad_cycles++;
            step();
        end
        total++;
        if (retires != 1 || bad_cycles != 0 || retire_count !== model_count) begin
            bad++;
            $display("FAIL mem_retire: retires=%0d req_after_ack=%0d count=%0d, required 1/0/%0d", retires, bad_cycles, retire_count, model_count);
        end
    endtask

    task automatic test_reset_mid_mem();
        int retires;
        accept_op(2'd2, 1'b0, 1'b0, 3'd0, 2'd2, 32'h0000_2000, 32'h5555_AAAA, 32'h0, 32'h0, 32'h0);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (mem_req !== 1'b0 || eflags_q !== 32'h2 || retire_count !== 32'd0) begin
            bad++;
            $display("FAIL rst_mem: mem_req=%b eflags=%h count=%0d, required 0/00000002/0", mem_req, eflags_q, retire_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_flags = 32'h2;
        model_count = 32'd0;
        retires = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (retire === 1'b1 || mem_req === 1'b1) retires++;
        end
        total++;
        if (retires != 0) begin
            bad++;
            $display("FAIL rst_no_retire: activity_cycles=%0d, required 0", retires);
        end
        test_add();
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force dut.retire_count_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.retire_count_q;
        model_count = 32'hFFFF_FFFF;
        model_flags = eflags_q;
        accept_op(2'd0, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0);
        total++;
        if (retire !== 1'b1) begin
            bad++;
            $display("FAIL wrap_retire: retire=%b, required 1", retire);
        end
        step();
        total++;
        if (retire_count !== 32'd0 || eflags_q !== model_flags) begin
            bad++;
            $display("FAIL wrap_count: count=%h eflags=%h, required 00000000/%h", retire_count, eflags_q, model_flags);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] kind;
        int n;
        mem_ack = 1'b1;
        for (int k = 0; k < 8; k++) begin
            kind = 2'($urandom_range(0, 3));
            accept_op(kind, 1'($urandom_range(0, 3) == 0), 1'($urandom), 3'($urandom), 2'($urandom),
                      $urandom, $urandom, $urandom, $urandom, $urandom);
            n = 0;
            while (retire !== 1'b1 && n < 20) begin
                step();
                n++;
            end
            total++;
            if (retire !== 1'b1) begin
                bad++;
                $display("FAIL b2b_retire_timeout: op=%0d retire=%b, required 1", k, retire);
            end
            step();
            total++;
            if (eflags_q !== model_flags || retire_count !== model_count) begin
                bad++;
                $display("FAIL b2b_state: op=%0d eflags=%h count=%0d, required %h/%0d", k, eflags_q, retire_count, model_flags, model_count);
            end
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        ex_valid      = 1'b0;
        ex_result     = 32'h0;
        ex_result_hi  = 32'h0;
        ex_wr_hi      = 1'b0;
        ex_no_wr      = 1'b0;
        ex_dst_kind   = 2'd0;
        ex_dst_reg    = 3'd0;
        ex_dst_size   = 2'd0;
        ex_dst_addr   = 32'h0;
        ex_flags      = 32'h0;
        ex_flags_mask = 32'h0;
        mem_ack       = 1'b0;
        model_flags   = 32'h2;
        model_count   = 32'd0;

        test_reset();
        test_add();
        test_mul(3'd0);
        test_mul(3'd2);
        test_cmp();
        test_mem();
        test_reset_mid_mem();
        test_wrap();
        test_back_to_back();

        step();
        total++;
        if (rf_q.size() != 0) begin
            bad++;
            $display("FAIL rf_pending: outstanding=%0d, required 0", rf_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
